pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generation stage, directly upstream of the branch predictor.
- Produces the fetch PC that the predictor looks up.
- Selects the next PC from four sources: trap/return redirect, Execute misprediction recovery, predictor taken decision, and sequential PC+4.
- Buffers redirects that arrive while the front end is stalled, and issues a one-cycle flush pulse to Fetch/Decode whenever a non-predicted redirect takes effect.

Parameters:
- XLEN, 32, datapath and address width.
- BOOT_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  front-end stall; PC holds while high.
- bpu_hit_i  in  1  predictor has a BTB hit for the current pc_o.
- bpu_decision_i  in  1  predictor says taken.
- bpu_target_i  in  XLEN  predicted target for the current pc_o.
- exe_mispredict_i  in  1  Execute resolved a branch against its prediction (single-cycle pulse).
- exe_taken_i  in  1  actual branch outcome at Execute.
- exe_target_i  in  XLEN  actual taken target from Execute.
- exe_pc_i  in  XLEN  PC of the branch at Execute.
- sys_jump_i  in  1  trap entry / xRET redirect (single-cycle pulse).
- sys_jump_addr_i  in  XLEN  trap/return destination.
- pc_o  out  XLEN  current fetch PC (registered).
- pred_taken_o  out  1  registered; 1 when pc_o was produced by a predictor taken decision.
- flush_o  out  1  registered one-cycle pulse; 1 when pc_o was produced by a sys or exe redirect.
- pend_o  out  1  a redirect is buffered awaiting stall release.

Behaviour:
- Reset (asynchronous, any cycle, including mid-stall or with a redirect pending):
  - pc_o=BOOT_ADDR, pred_taken_o=0, flush_o=0, pend_o=0.
  - Pending state returns to IDLE and pending address is cleared to 0.
- Event candidates and priority, evaluated each cycle:
  - sys_jump_i → sys_jump_addr_i.
  - exe_mispredict_i → exe_taken_i ? exe_target_i : exe_pc_i+4.
  - Priority: sys > exe > predictor > sequential.
- Address rules:
  - All selected addresses have bits [1:0] forced to 0.
  - exe_pc_i+4 and pc_o+4 wrap modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- Pending state machine, states IDLE, PEND_EXE, PEND_SYS:
  - IDLE with stall_i=1:
    - sys event → PEND_SYS.
    - else exe event → PEND_EXE.
    - Address is captured in both cases.
  - PEND_EXE with stall_i=1:
    - New sys → PEND_SYS with the new address.
    - New exe overwrites the address, state stays PEND_EXE.
  - PEND_SYS with stall_i=1:
    - New sys overwrites the address.
    - exe events are ignored.
  - Any state with stall_i=0:
    - Next PC = highest of {live sys, pending SYS, live exe, pending EXE, predictor, seq}.
    - A live sys beats a pending EXE. A pending SYS beats a live exe.
    - A pending EXE and a live exe cannot coexist by protocol; if they do, the live one wins.
    - State returns to IDLE.
  - pend_o = (state != IDLE).
- Next-PC update when stall_i=0 (1-cycle latency from select to pc_o):
  - Redirect (sys/exe, live or pending): pc_o←addr, flush_o←1, pred_taken_o←0.
  - Else bpu_hit_i & bpu_decision_i: pc_o←bpu_target_i & ~3, pred_taken_o←1, flush_o←0.
  - Else: pc_o←pc_o+4, pred_taken_o←0, flush_o←0.
- When stall_i=1:
  - pc_o and pred_taken_o hold.
  - flush_o←0; no flush is issued while stalled, and the flush is deferred to release.
  - Predictor inputs are ignored.
- bpu_hit_i without bpu_decision_i is treated as not-taken (sequential).

Test Plan:
- Reset release, no events, stall_i=0 for 4 cycles → pc_o 0x0, 0x4, 0x8, 0xC; flush_o=0 throughout. Assert rst_i asynchronously mid-cycle → pc_o=0x0 immediately.
- At pc_o=0x100 drive bpu_hit_i=1, bpu_decision_i=1, bpu_target_i=0x203 → next pc_o=0x200, pred_taken_o=1, flush_o=0. Then hit=1, decision=0 → pc_o=0x204, pred_taken_o=0.
- exe_mispredict_i=1, exe_taken_i=0, exe_pc_i=0x200, with a concurrent predictor taken to 0x400 → pc_o=0x204, flush_o=1 for exactly one cycle, pred_taken_o=0.
- Same cycle sys_jump_i=1 (addr 0x8000_0000) and exe_mispredict_i=1 (target 0x300) → pc_o=0x8000_0000, single flush pulse.
- stall_i=1 for 3 cycles; exe mispredict (taken, 0x500) in cycle 1, sys_jump (0x900) in cycle 2 → pend_o=1 from cycle 2, pc_o held. On release, pc_o=0x900 with one flush pulse, pend_o=0.
- Pending EXE (0x500) under stall, then rst_i pulse → pend_o=0, pc_o=0x0. After release, sequential from 0x0 with no flush.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generation: selects among trap/return, Execute recovery, predictor
// and sequential next-PC, holding redirects that arrive while stalled.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            bpu_hit_i,
  input  logic            bpu_decision_i,
  input  logic [XLEN-1:0] bpu_target_i,
  input  logic            exe_mispredict_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            sys_jump_i,
  input  logic [XLEN-1:0] sys_jump_addr_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic            flush_o,
  output logic            pend_o
);

  localparam logic [XLEN-1:0] MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, PEND_EXE, PEND_SYS} pend_st_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] addr;
  } redir_t;

  pend_st_t        st;
  logic [XLEN-1:0] pend_addr;
  redir_t          sys_r, exe_r, sel_r;

  always_comb begin
    sys_r.vld  = sys_jump_i;
    sys_r.addr = sys_jump_addr_i & MASK;
    exe_r.vld  = exe_mispredict_i;
    exe_r.addr = (exe_taken_i ? exe_target_i : exe_pc_i + XLEN'(4)) & MASK;
  end

  // Release ordering: live sys, pending sys, live exe, pending exe.
  always_comb begin
    sel_r = '0;
    if (sys_r.vld)          sel_r = sys_r;
    else if (st == PEND_SYS) sel_r = '{vld: 1'b1, addr: pend_addr};
    else if (exe_r.vld)     sel_r = exe_r;
    else if (st == PEND_EXE) sel_r = '{vld: 1'b1, addr: pend_addr};
  end

  assign pend_o = (st != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o         <= BOOT_ADDR;
      pred_taken_o <= 1'b0;
      flush_o      <= 1'b0;
      st           <= IDLE;
      pend_addr    <= '0;
    end else if (stall_i) begin
      // PC holds; redirects are parked and the flush waits for release.
      flush_o <= 1'b0;
      case (st)
        IDLE: begin
          if (sys_r.vld) begin
            st        <= PEND_SYS;
            pend_addr <= sys_r.addr;
          end else if (exe_r.vld) begin
            st        <= PEND_EXE;
            pend_addr <= exe_r.addr;
          end
        end
        PEND_EXE: begin
          if (sys_r.vld) begin
            st        <= PEND_SYS;
            pend_addr <= sys_r.addr;
          end else if (exe_r.vld) begin
            pend_addr <= exe_r.addr;
          end
        end
        PEND_SYS: begin
          if (sys_r.vld) pend_addr <= sys_r.addr;
        end
        default: st <= IDLE;
      endcase
    end else begin
      st <= IDLE;
      if (sel_r.vld) begin
        pc_o         <= sel_r.addr;
        flush_o      <= 1'b1;
        pred_taken_o <= 1'b0;
      end else if (bpu_hit_i && bpu_decision_i) begin
        pc_o         <= bpu_target_i & MASK;
        flush_o      <= 1'b0;
        pred_taken_o <= 1'b1;
      end else begin
        pc_o         <= pc_o + XLEN'(4);
        flush_o      <= 1'b0;
        pred_taken_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic against a
// rank-based model of redirect buffering.
module tb_pc_gen;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, bpu_hit_i, bpu_decision_i;
  logic [31:0] bpu_target_i;
  logic        exe_mispredict_i, exe_taken_i;
  logic [31:0] exe_target_i, exe_pc_i;
  logic        sys_jump_i;
  logic [31:0] sys_jump_addr_i;
  logic [31:0] pc_o;
  logic        pred_taken_o, flush_o, pend_o;

  always #5 clk_i = ~clk_i;

  pc_gen #(.XLEN(32), .BOOT_ADDR(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .bpu_hit_i(bpu_hit_i), .bpu_decision_i(bpu_decision_i), .bpu_target_i(bpu_target_i),
    .exe_mispredict_i(exe_mispredict_i), .exe_taken_i(exe_taken_i),
    .exe_target_i(exe_target_i), .exe_pc_i(exe_pc_i),
    .sys_jump_i(sys_jump_i), .sys_jump_addr_i(sys_jump_addr_i),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .flush_o(flush_o), .pend_o(pend_o)
  );

  int total = 0, bad = 0;

  // Model: a parked redirect is described by its rank (0 none, 1 exe, 2 sys);
  // under stall a new event replaces the parked one if its rank is not lower.
  logic [31:0] m_pc, m_paddr;
  logic        m_pt, m_fl;
  int          m_rank;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task mreset();
    m_pc = 32'h0; m_pt = 1'b0; m_fl = 1'b0; m_rank = 0; m_paddr = 32'h0;
  endtask

  task clr();
    stall_i = 0; bpu_hit_i = 0; bpu_decision_i = 0; bpu_target_i = 0;
    exe_mispredict_i = 0; exe_taken_i = 0; exe_target_i = 0; exe_pc_i = 0;
    sys_jump_i = 0; sys_jump_addr_i = 0;
  endtask

  task tick();
    logic [31:0] sa, ea, n_pc, n_paddr;
    logic        n_pt, n_fl;
    int          n_rank;
    sa = {sys_jump_addr_i[31:2], 2'b00};
    ea = exe_taken_i ? exe_target_i : exe_pc_i + 32'd4;
    ea = {ea[31:2], 2'b00};
    n_pc = m_pc; n_pt = m_pt; n_fl = 1'b0; n_rank = m_rank; n_paddr = m_paddr;
    if (stall_i) begin
      if (sys_jump_i && 2 >= m_rank) begin n_rank = 2; n_paddr = sa; end
      else if (exe_mispredict_i && 1 >= m_rank) begin n_rank = 1; n_paddr = ea; end
    end else begin
      n_rank = 0;
      n_fl = 1'b1; n_pt = 1'b0;
      if (sys_jump_i)            n_pc = sa;
      else if (m_rank == 2)      n_pc = m_paddr;
      else if (exe_mispredict_i) n_pc = ea;
      else if (m_rank == 1)      n_pc = m_paddr;
      else begin
        n_fl = 1'b0;
        if (bpu_hit_i && bpu_decision_i) begin
          n_pc = {bpu_target_i[31:2], 2'b00}; n_pt = 1'b1;
        end else begin
          n_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk_i);
    #1;
    m_pc = n_pc; m_pt = n_pt; m_fl = n_fl; m_rank = n_rank; m_paddr = n_paddr;
    chk("pc", pc_o, m_pc);
    chk("pred_taken", {31'b0, pred_taken_o}, {31'b0, m_pt});
    chk("flush", {31'b0, flush_o}, {31'b0, m_fl});
    chk("pend", {31'b0, pend_o}, {31'b0, m_rank != 0});
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task async_rst();
    #2 rst_i = 1'b1;
    #1;
    mreset();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pend", {31'b0, pend_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_pt", {31'b0, pred_taken_o}, 32'h0);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    mreset();
    #12;
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_pend", {31'b0, pend_o}, 32'h0);
    rst_i = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", pc_o, 32'(i * 4));
    end
    async_rst();

    // Predictor taken then hit-but-not-taken
    sys_jump_i = 1; sys_jump_addr_i = 32'h100; tick(); clr();
    tick(); // flush drops, pc 0x104
    sys_jump_i = 1; sys_jump_addr_i = 32'h100; tick(); clr();
    chk("at_100", pc_o, 32'h100);
    bpu_hit_i = 1; bpu_decision_i = 1; bpu_target_i = 32'h203; tick();
    chk("pred_pc", pc_o, 32'h200);
    chk("pred_pt", {31'b0, pred_taken_o}, 32'h1);
    bpu_decision_i = 0; tick(); clr();
    chk("nt_pc", pc_o, 32'h204);

    // Exe not-taken recovery beats predictor
    exe_mispredict_i = 1; exe_taken_i = 0; exe_pc_i = 32'h200;
    bpu_hit_i = 1; bpu_decision_i = 1; bpu_target_i = 32'h400; tick(); clr();
    chk("exe_pc", pc_o, 32'h204);
    chk("exe_flush", {31'b0, flush_o}, 32'h1);
    tick();
    chk("exe_flush_end", {31'b0, flush_o}, 32'h0);

    // Sys beats exe in the same cycle
    sys_jump_i = 1; sys_jump_addr_i = 32'h8000_0000;
    exe_mispredict_i = 1; exe_taken_i = 1; exe_target_i = 32'h300; tick(); clr();
    chk("sys_pc", pc_o, 32'h8000_0000);
    tick();

    // Redirects under stall
    stall_i = 1; exe_mispredict_i = 1; exe_taken_i = 1; exe_target_i = 32'h500; tick();
    chk("stall_pend", {31'b0, pend_o}, 32'h1);
    exe_mispredict_i = 0; sys_jump_i = 1; sys_jump_addr_i = 32'h900; tick();
    sys_jump_i = 0; tick();
    stall_i = 0; tick();
    chk("rel_pc", pc_o, 32'h900);
    chk("rel_flush", {31'b0, flush_o}, 32'h1);
    chk("rel_pend", {31'b0, pend_o}, 32'h0);
    tick();

    // Reset while a redirect is parked
    stall_i = 1; exe_mispredict_i = 1; exe_taken_i = 1; exe_target_i = 32'h500; tick();
    async_rst();
    clr();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("post_rst_pc", pc_o, 32'(i * 4));
    end

    // Address wrap
    sys_jump_i = 1; sys_jump_addr_i = 32'hFFFF_FFFF; tick(); clr();
    chk("wrap_mask", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_seq", pc_o, 32'h0);
    exe_mispredict_i = 1; exe_taken_i = 0; exe_pc_i = 32'hFFFF_FFFC; tick(); clr();
    chk("wrap_exe", pc_o, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      stall_i          = ($urandom_range(99) < 30);
      bpu_hit_i        = $urandom_range(1);
      bpu_decision_i   = $urandom_range(1);
      bpu_target_i     = $urandom;
      exe_mispredict_i = ($urandom_range(99) < 15);
      exe_taken_i      = $urandom_range(1);
      exe_target_i     = $urandom;
      exe_pc_i         = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom;
      sys_jump_i       = ($urandom_range(99) < 10);
      sys_jump_addr_i  = $urandom;
      if ($urandom_range(299) == 0) async_rst();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
